// File: rtl/count_bcd_display_pkg.sv
// Shared constants for the BCD display path: segment codes, FSM encoding,
// and the BCD-to-segment lookup used by the decoder.
package count_bcd_display_pkg;

    localparam int BCD_W = 4;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// Bundle between the pulse counter / display driver and the BCD converter.
// The master side supplies count results; the slave side is the converter.
interface count_bcd_display_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    value;
    logic                valid;
    logic [4*DIGITS-1:0] digits;
    logic                digits_valid;
    logic                busy;
    logic                overrun;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    modport master (
        output value, valid,
        input  digits, digits_valid, busy, overrun, seg, an
    );

    modport slave (
        input  value, valid,
        output digits, digits_valid, busy, overrun, seg, an
    );
endinterface

// File: rtl/count_bcd_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder with a blank override.
module seg7_decode
    import count_bcd_display_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    input  logic             i_blank,
    output logic [6:0]       o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_bcd);

endmodule

// File: rtl/count_bcd_display.sv
// Double-dabble binary-to-BCD converter feeding a multiplexed common-anode
// 7-segment display with leading-zero blanking.
module count_bcd_display
    import count_bcd_display_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    count_bcd_display_if.slave   bus
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int BIT_W   = $clog2(WIDTH + 1);
    localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_bin, w_bin_next;
    logic [BCD_TOT-1:0]   r_bcd, w_bcd_next;
    logic [BCD_TOT-1:0]   w_bcd_adj;
    logic [BCD_TOT-1:0]   w_bcd_shift;
    logic [WIDTH-1:0]     w_bin_shift;
    logic [BIT_W-1:0]     r_bitcnt, w_bitcnt_next;
    logic [BCD_TOT-1:0]   r_digits, w_digits_next;
    logic                 r_busy, w_busy_next;
    logic                 r_dv, w_dv_next;
    logic                 r_ov, w_ov_next;

    logic [CNT_W-1:0]     r_scan_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DIGITS-1:0]    r_an, w_an_next;
    logic [6:0]           r_seg, w_seg;
    logic [BCD_W-1:0]     w_nibble;
    logic [DIGITS-1:0]    w_lz;
    logic                 w_blank;

    // Add-3 correction on every nibble, then one combined left shift
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*BCD_W +: BCD_W] >= 4'd5)
                w_bcd_adj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + 4'd3;
            else
                w_bcd_adj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W];
        end
        w_bcd_shift = {w_bcd_adj[BCD_TOT-2:0], r_bin[WIDTH-1]};
        w_bin_shift = {r_bin[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        w_state_next  = r_state;
        w_bin_next    = r_bin;
        w_bcd_next    = r_bcd;
        w_bitcnt_next = r_bitcnt;
        w_digits_next = r_digits;
        w_busy_next   = r_busy;
        w_dv_next     = 1'b0;
        w_ov_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid) begin
                    w_bin_next    = bus.value;
                    w_bcd_next    = '0;
                    w_bitcnt_next = '0;
                    w_busy_next   = 1'b1;
                    w_state_next  = SHIFT;
                end
            end
            SHIFT: begin
                w_bin_next    = w_bin_shift;
                w_bcd_next    = w_bcd_shift;
                w_bitcnt_next = r_bitcnt + BIT_W'(1);
                w_ov_next     = bus.valid;
                if (r_bitcnt == BIT_W'(WIDTH - 1)) begin
                    w_digits_next = w_bcd_shift;
                    w_dv_next     = 1'b1;
                    w_busy_next   = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_digits <= '0;
            r_busy   <= 1'b0;
            r_dv     <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bitcnt <= w_bitcnt_next;
            r_digits <= w_digits_next;
            r_busy   <= w_busy_next;
            r_dv     <= w_dv_next;
            r_ov     <= w_ov_next;
        end
    end

    // Shift registers are always (re)loaded before use, so they carry no reset
    always_ff @(posedge clk) begin
        r_bin <= w_bin_next;
        r_bcd <= w_bcd_next;
    end

    // w_lz[i]: digit i and every digit above it are zero
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_zero_run = v_zero_run & (r_digits[i*BCD_W +: BCD_W] == 4'd0);
            w_lz[i]    = v_zero_run;
        end
    end

    always_comb begin
        w_nibble  = '0;
        w_blank   = 1'b0;
        w_an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble     = r_digits[i*BCD_W +: BCD_W];
                w_blank      = (BLANK_LZ != 0) && (i != 0) && w_lz[i];
                w_an_next[i] = 1'b0;
            end
        end
    end

    seg7_decode u_seg7_decode (
        .i_bcd   (w_nibble),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= '1;
            r_seg      <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
            end
            r_an  <= w_an_next;
            r_seg <= w_seg;
        end
    end

    assign bus.digits       = r_digits;
    assign bus.digits_valid = r_dv;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_ov;
    assign bus.seg          = r_seg;
    assign bus.an           = r_an;

endmodule
